// File: rtl/ann_pkg.sv
// Shared types and helpers for the neuron unit: FSM state enum,
// default sizing and the output saturation function.
package ann_pkg;

  localparam int DEF_N_IN = 3;
  localparam int DEF_DW   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } neuron_state_t;

  // Clamp a wide signed value into the signed range of a dw-bit word.
  // The result stays 64 bits wide so callers can cast it to their own width.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (v > hi) begin
      sat = hi;
    end else if (v < lo) begin
      sat = lo;
    end else begin
      sat = v;
    end
  endfunction

endpackage

// File: rtl/ann_mac_slice.sv
// Registered signed multiply-accumulate slice. clr loads the start value
// (bias), en adds one full-width product, otherwise the accumulator holds.
module ann_mac_slice #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [ACC_W-1:0] init,
  input  logic signed [DW-1:0]    a,
  input  logic signed [DW-1:0]    b,
  output logic signed [ACC_W-1:0] acc
);

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;

  // Full-precision signed product, sign-extended to accumulator width.
  always_comb begin
    prod     = a * b;
    prod_ext = {{(ACC_W - 2*DW){prod[2*DW-1]}}, prod};
  end

  // Accumulator: load on clr, accumulate on en, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= init;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end

endmodule

// File: rtl/ann_neuron_unit.sv
// One neuron: N_IN-input signed MAC plus bias, started by a rising edge on
// en, reporting completion through ready/done. Optional build macro
// NEURON_RELU_EN fuses a ReLU in front of the saturating output stage.
module ann_neuron_unit
  import ann_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int DW    = DEF_DW,
  parameter int ACC_W = 2*DW + $clog2(N_IN) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_IN*DW-1:0]         x_in,
  input  logic                       w_we,
  input  logic [$clog2(N_IN+1)-1:0]  w_addr,
  input  logic [DW-1:0]              w_data,
  output logic                       ready,
  output logic                       done,
  output logic signed [DW-1:0]       y
);

  localparam int AW = $clog2(N_IN + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);
  localparam logic [AW-1:0] BIAS_ADDR = AW'(N_IN);

  neuron_state_t state;
  neuron_state_t state_next;

  logic                    en_q;
  logic                    idle;
  logic                    start;
  logic                    mac_en;
  logic                    bias_wr;
  logic [AW-1:0]           idx;

  logic signed [DW-1:0]    w_reg [N_IN];
  logic signed [DW-1:0]    x_reg [N_IN];
  logic signed [DW-1:0]    bias_reg;

  logic signed [DW-1:0]    bias_eff;
  logic signed [ACC_W-1:0] acc_init;
  logic signed [DW-1:0]    mac_a;
  logic signed [DW-1:0]    mac_b;
  logic signed [ACC_W-1:0] acc;
  logic signed [63:0]      acc_wide;
  logic signed [DW-1:0]    y_next;

  // Start detection, write qualification and operand selection. A bias
  // written on the start edge is bypassed so the new computation sees it.
  always_comb begin
    idle     = (state == IDLE);
    start    = en & ~en_q & idle;
    mac_en   = (state == MAC);
    bias_wr  = w_we & idle & (w_addr == BIAS_ADDR);
    bias_eff = bias_wr ? $signed(w_data) : bias_reg;
    acc_init = {{(ACC_W - DW){bias_eff[DW-1]}}, bias_eff};
    mac_a    = w_reg[idx];
    mac_b    = x_reg[idx];
  end

  // Output value: saturate the final sum, optionally zeroing negatives.
  always_comb begin
    acc_wide = {{(64 - ACC_W){acc[ACC_W-1]}}, acc};
`ifdef NEURON_RELU_EN
    y_next = acc[ACC_W-1] ? '0 : DW'(sat(acc_wide, DW));
`else
    y_next = DW'(sat(acc_wide, DW));
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one MAC cycle per input, then a single output cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = MAC;
        end
      end
      MAC: begin
        if (idx == LAST_IDX) begin
          state_next = OUT;
        end
      end
      OUT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Edge detector history for en; tracks en every cycle regardless of state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= en;
    end
  end

  // Weight and bias storage; writes are only accepted while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        w_reg[i] <= '0;
      end
      bias_reg <= '0;
    end else if (idle && w_we) begin
      for (int i = 0; i < N_IN; i++) begin
        if (w_addr == AW'(i)) begin
          w_reg[i] <= $signed(w_data);
        end
      end
      if (bias_wr) begin
        bias_reg <= $signed(w_data);
      end
    end
  end

  // Input snapshot taken on the start edge so later x_in changes are harmless.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_IN; i++) begin
        x_reg[i] <= '0;
      end
    end else if (start) begin
      for (int i = 0; i < N_IN; i++) begin
        x_reg[i] <= $signed(x_in[i*DW +: DW]);
      end
    end
  end

  // Operand index: cleared at start, stepped once per MAC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (start) begin
      idx <= '0;
    end else if (mac_en) begin
      idx <= idx + AW'(1);
    end
  end

  // Handshake and result registers: ready drops at start, and the output
  // cycle publishes y with ready and a one-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready <= 1'b1;
      done  <= 1'b0;
      y     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        ready <= 1'b0;
      end
      if (state == OUT) begin
        y     <= y_next;
        ready <= 1'b1;
        done  <= 1'b1;
      end
    end
  end

  // Single shared MAC slice, fed through the idx operand muxes.
  ann_mac_slice #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (mac_en),
    .init (acc_init),
    .a    (mac_a),
    .b    (mac_b),
    .acc  (acc)
  );

endmodule

// File: tb/tb_ann_neuron_unit.sv
// Self-checking bench for ann_neuron_unit (N_IN=3, DW=8). A transaction-level
// model predicts ready/done/y every cycle; directed tests add literal checks.
module tb_ann_neuron_unit;

  logic              clk;
  logic              rst;
  logic              en;
  logic [23:0]       x_in;
  logic              w_we;
  logic [1:0]        w_addr;
  logic [7:0]        w_data;
  logic              ready;
  logic              done;
  logic signed [7:0] y;

  int n_compared   = 0;
  int n_mismatched = 0;

`ifdef NEURON_RELU_EN
  localparam int RELU_EXP = 0;
`else
  localparam int RELU_EXP = -50;
`endif

  ann_neuron_unit #(
    .N_IN (3),
    .DW   (8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .x_in   (x_in),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .ready  (ready),
    .done   (done),
    .y      (y)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model state
  int   m_w [3];
  int   m_b       = 0;
  logic m_en_prev = 1'b0;
  int   m_cnt     = 0;
  int   m_pending = 0;
  logic m_ready   = 1'b1;
  logic m_done    = 1'b0;
  int   m_y       = 0;

  // Expected neuron result from the stored parameters and current inputs.
  function automatic int neuronResult();
    int s;
    s = m_b;
    for (int i = 0; i < 3; i++) begin
      s += m_w[i] * int'($signed(x_in[8*i +: 8]));
    end
    if (s > 127) s = 127;
    if (s < -128) s = -128;
`ifdef NEURON_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // Model: an accepted start delivers its result N_IN+1 edges later; while
  // a result is pending, starts and parameter writes are ignored.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) m_w[i] = 0;
      m_b       = 0;
      m_en_prev = 1'b0;
      m_cnt     = 0;
      m_pending = 0;
      m_ready   = 1'b1;
      m_done    = 1'b0;
      m_y       = 0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_ready = 1'b1;
          m_done  = 1'b1;
          m_y     = m_pending;
        end
      end else begin
        if (w_we) begin
          if (w_addr == 2'd0) m_w[0] = int'($signed(w_data));
          if (w_addr == 2'd1) m_w[1] = int'($signed(w_data));
          if (w_addr == 2'd2) m_w[2] = int'($signed(w_data));
          if (w_addr == 2'd3) m_b    = int'($signed(w_data));
        end
        if (en && !m_en_prev) begin
          m_pending = neuronResult();
          m_cnt     = 4;
          m_ready   = 1'b0;
        end
      end
      m_en_prev = en;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    checkOutput("ready", int'(ready), int'(m_ready));
    checkOutput("done", int'(done), int'(m_done));
    checkOutput("y", int'(y), m_y);
  end

  // Drive one cycle of inputs, returning at the following negedge.
  task automatic applyStimulus(input logic en_v, input logic we_v,
                               input logic [1:0] addr_v, input logic [7:0] data_v);
    en     = en_v;
    w_we   = we_v;
    w_addr = addr_v;
    w_data = data_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic writeParam(input int addr, input int data);
    applyStimulus(1'b0, 1'b1, 2'(addr), 8'(data));
  endtask

  task automatic setX(input int a, input int b, input int c);
    x_in = {8'(c), 8'(b), 8'(a)};
  endtask

  task automatic loadNeuron(input int w0, input int w1, input int w2, input int b);
    writeParam(0, w0);
    writeParam(1, w1);
    writeParam(2, w2);
    writeParam(3, b);
  endtask

  // Wait (bounded) for ready, counting the busy cycles seen.
  task automatic waitReady(output int low);
    low = 0;
    while (!ready && low < 20) begin
      low++;
      applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    end
    if (low >= 20) checkOutput("wait_ready_timeout", int'(ready), 1);
  endtask

  // Pulse en for one cycle (optionally with a write on the start edge).
  task automatic runOne(input logic we_v, input int addr, input int data, output int low);
    applyStimulus(1'b1, we_v, 2'(addr), 8'(data));
    if (!ready) waitReady(low);
    else begin
      low = 0;
      checkOutput("start_accepted", int'(ready), 0);
    end
  endtask

  initial begin
    int low;
    int dones;
    rst    = 1'b1;
    en     = 1'b0;
    w_we   = 1'b0;
    w_addr = 2'd0;
    w_data = 8'd0;
    x_in   = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", int'(ready), 1);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_y", int'(y), 0);
    rst = 1'b0;

    // Basic: 2*10 - 20 + 3*5 + 4 = 19
    loadNeuron(2, -1, 3, 4);
    setX(10, 20, 5);
    runOne(1'b0, 0, 0, low);
    checkOutput("basic_busy_cycles", low, 4);
    checkOutput("basic_done", int'(done), 1);
    checkOutput("basic_y", int'(y), 19);
    checkOutput("model_basic_y", m_y, 19);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    checkOutput("done_one_cycle", int'(done), 0);

    // Positive saturation: 3*127*127 clamps to 127
    loadNeuron(127, 127, 127, 0);
    setX(127, 127, 127);
    runOne(1'b0, 0, 0, low);
    checkOutput("sat_pos_y", int'(y), 127);
    checkOutput("model_sat_pos_y", m_y, 127);

    // Negative saturation: 3*127*(-128) clamps to -128
    setX(-128, -128, -128);
    runOne(1'b0, 0, 0, low);
    checkOutput("sat_neg_y", int'(y), -128);

    // Negative sum: linear gives -50, ReLU build gives 0
    loadNeuron(-1, 0, 0, 0);
    setX(50, 0, 0);
    runOne(1'b0, 0, 0, low);
    checkOutput("relu_y", int'(y), RELU_EXP);
    checkOutput("model_relu_y", m_y, RELU_EXP);

    // en held high for 20 cycles: exactly one computation
    loadNeuron(2, -1, 3, 4);
    setX(10, 20, 5);
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
      if (done) dones++;
    end
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    if (done) dones++;
    checkOutput("en_held_dones", dones, 1);
    checkOutput("en_held_y", int'(y), 19);

    // en toggled while busy: the second rise is not queued
    dones = 0;
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
      if (done) dones++;
    end
    checkOutput("toggle_busy_dones", dones, 1);

    // Weight write during MAC is ignored
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'd0, 8'd100);
    waitReady(low);
    checkOutput("busy_write_y", int'(y), 19);
    runOne(1'b0, 0, 0, low);
    checkOutput("busy_write_storage_y", int'(y), 19);

    // Write on the start edge while idle is used: 1000-20+15+4 clamps to 127
    runOne(1'b1, 0, 100, low);
    checkOutput("idle_write_y", int'(y), 127);
    checkOutput("model_idle_write_y", m_y, 127);

    // Out-of-range x change after start has no effect; reset mid-MAC
    applyStimulus(1'b1, 1'b0, 2'd0, 8'd0);
    setX(0, 0, 0);
    applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset_ready", int'(ready), 1);
    checkOutput("midreset_y", int'(y), 0);
    checkOutput("midreset_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    setX(10, 20, 5);
    runOne(1'b0, 0, 0, low);
    checkOutput("after_reset_busy_cycles", low, 4);
    checkOutput("after_reset_y", int'(y), 0);
    checkOutput("model_after_reset_y", m_y, 0);

    repeat (2) applyStimulus(1'b0, 1'b0, 2'd0, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
